rank_score_selector: RTL and testbench
======================================

Name: rank_score_selector

Overview:
- Consumer end of the per-rank XOR template matchers: collects one mismatch score per rank kernel for each card corner and selects the best-matching rank.
- Each matcher emits a score plus a one-cycle valid strobe when its read-out pass finishes.
- Buffers all scores, serially finds the minimum and runner-up, and presents the rank index with a confidence flag over a valid/ready handshake to the game-logic layer.

Parameters:
NUM_RANKS, 13, number of rank matchers; index 0..12 = A,2..10,J,Q,K
SCORE_W, 11, score width; clog2(28*40=1120)
TIMEOUT, 4096, cycles after first strobe before comparing with missing scores
MATCH_THRESH, 300, best score must be strictly below this to be confident
MIN_MARGIN, 50, runner-up minus best must be >= this to be confident

Ports:
clk  in  1  clock
rst  in  1  reset
score_in  in  NUM_RANKS*SCORE_W  flattened scores; rank i at bits [i*SCORE_W +: SCORE_W]
score_valid  in  NUM_RANKS  per-rank one-cycle strobe; score_in slice valid only that cycle
rank_idx  out  4  winning rank index
best_score  out  SCORE_W  minimum score
second_score  out  SCORE_W  runner-up score; all-ones if fewer than two present
confident  out  1  best_score<MATCH_THRESH && (second_score-best_score)>=MIN_MARGIN && no score missing
missing  out  NUM_RANKS  ranks absent when comparison started
rank_valid  out  1  result valid
rank_ready  in  1  consumer accepts
drop_count  out  8  saturating count of strobes discarded outside COLLECT

Behaviour:
- Reset is synchronous, active-high, on clk. On reset:
  - state=COLLECT; all latched-present bits 0; timeout counter 0.
  - rank_valid=0, rank_idx=0, best_score=0, second_score=all-ones, confident=0, missing=0, drop_count=0.
- Reset asserted mid-COMPARE or mid-OUTPUT aborts the operation; no result is delivered.
- COLLECT:
  - On score_valid[i], latch slice i into buffer[i] and set present[i].
  - A repeated strobe for an already-present rank overwrites the buffer; no drop is counted.
  - Timeout counter is idle until the first strobe, then increments every cycle.
  - Go to COMPARE at the edge where present (including same-cycle strobes) becomes all ones, or when the counter reaches TIMEOUT-1.
  - On the transition: missing <= ~present_next.
- COMPARE:
  - Iterator j runs 0..NUM_RANKS-1, one entry per cycle; non-present entries are skipped but still consume a cycle.
  - Running best starts at all-ones; the compare is strict less-than, so ties resolve to the lowest index.
  - When the best is displaced, the old best moves to second. Otherwise, second is updated if the entry is strictly below it.
  - After j=NUM_RANKS-1: register outputs, compute confident, set rank_valid=1, go to OUTPUT.
  - confident: the margin subtraction is unsigned, and second=all-ones is the saturated case. confident=0 if any missing bit is set.
- Latency: rank_valid rises exactly NUM_RANKS cycles after the edge that entered COMPARE (13 cycles by default).
- OUTPUT:
  - rank_valid and all result outputs are held stable until rank_ready=1 is sampled while rank_valid=1.
  - On that edge: rank_valid<=0, present<=0, counter<=0, go to COLLECT.
  - rank_ready while rank_valid=0 has no effect.
- Strobes arriving in COMPARE or OUTPUT are discarded.
  - drop_count increments by 1 per cycle with any strobe (not per bit) and saturates at 255.
  - drop_count is cleared only by reset.
  - Strobes on the acceptance edge are also dropped.
- Width rules:
  - Scores are unsigned SCORE_W.
  - The timeout counter is clog2(TIMEOUT) bits and never wraps: it stops at the transition and clears on return to COLLECT.

Test Plan:
- All 13 strobes in one cycle; scores = 900 except rank 6 = 40 and rank 2 = 400 -> rank_valid 13 cycles later; rank_idx=6, best=40, second=400, confident=1, missing=0.
- Strobes staggered over 13 cycles; ranks 3 and 9 both = 120, others 1000 -> rank_idx=3, best=120, second=120, confident=0 (margin 0).
- Only ranks 0..11 strobe; TIMEOUT=16 -> COMPARE starts 15 cycles after the first strobe; missing=0x1000, confident=0 even with best=10.
- Hold rank_ready=0 for 20 cycles after rank_valid -> outputs stable throughout; strobes injected meanwhile give drop_count=number of strobe cycles; ready=1 -> next card processed normally.
- Assert rst during COMPARE -> rank_valid never rises; a subsequent full strobe set yields a correct result with no stale entries.
- Single present rank with score 100 at timeout -> second=2047, confident=0 (rank missing).

Source files
------------

// File: rtl/rank_score_selector.sv
// rank_score_selector
//   Gathers one mismatch score from each rank template matcher for a card
//   corner, then walks the buffered scores serially to find the lowest score
//   (winning rank) and the runner-up. It presents the winner with a confidence
//   flag over a valid/ready handshake.
//
//   State   | meaning
//   --------+--------------------------------------------------------------
//   COLLECT | latch strobed scores; timeout runs once the first score lands
//   COMPARE | one buffer entry per cycle, tracking best and runner-up
//   OUTPUT  | result held on rank_* until the consumer accepts it
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   score_in      flattened scores, rank i at [i*SCORE_W +: SCORE_W]
//   score_valid   per-rank one-cycle strobe qualifying its score_in slice
//   rank_idx      winning rank index (0=A .. 12=K)
//   best_score    lowest score
//   second_score  runner-up score, all-ones if fewer than two were present
//   confident     best clearly below threshold, clear margin, nothing missing
//   missing       ranks not present when the comparison started
//   rank_valid    result valid; rank_ready accepts it
//   drop_count    saturating count of cycles with strobes outside COLLECT
module rank_score_selector #(
    parameter int NUM_RANKS    = 13,
    parameter int SCORE_W      = 11,
    parameter int TIMEOUT      = 4096,
    parameter int MATCH_THRESH = 300,
    parameter int MIN_MARGIN   = 50
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RANKS*SCORE_W-1:0]   score_in,
    input  logic [NUM_RANKS-1:0]           score_valid,
    output logic [3:0]                     rank_idx,
    output logic [SCORE_W-1:0]             best_score,
    output logic [SCORE_W-1:0]             second_score,
    output logic                           confident,
    output logic [NUM_RANKS-1:0]           missing,
    output logic                           rank_valid,
    input  logic                           rank_ready,
    output logic [7:0]                     drop_count
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {COLLECT, COMPARE, OUTPUT} state_t;

    state_t               state_q, state_d;
    logic [NUM_RANKS-1:0] present_q, present_d;
    logic [SCORE_W-1:0]   score_buf_q [NUM_RANKS];
    logic [SCORE_W-1:0]   score_buf_d [NUM_RANKS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           j_q, j_d;
    logic [SCORE_W-1:0]   run_best_q, run_best_d;
    logic [SCORE_W-1:0]   run_second_q, run_second_d;
    logic [3:0]           run_idx_q, run_idx_d;
    logic [3:0]           rank_idx_q, rank_idx_d;
    logic [SCORE_W-1:0]   best_q, best_d;
    logic [SCORE_W-1:0]   second_q, second_d;
    logic                 conf_q, conf_d;
    logic [NUM_RANKS-1:0] missing_q, missing_d;
    logic                 valid_q, valid_d;
    logic [7:0]           drop_q, drop_d;

    logic [SCORE_W-1:0]   entry_score;
    logic                 entry_present;
    logic [SCORE_W-1:0]   cand_best, cand_second;
    logic [3:0]           cand_idx;
    logic                 any_strobe;

    // Running best/second after folding in entry j. A displaced best becomes
    // the runner-up; strict compares keep the lowest index on ties.
    always_comb begin
        entry_score   = score_buf_q[j_q];
        entry_present = present_q[j_q];
        cand_best     = run_best_q;
        cand_second   = run_second_q;
        cand_idx      = run_idx_q;
        if (entry_present) begin
            if (entry_score < run_best_q) begin
                cand_best   = entry_score;
                cand_second = run_best_q;
                cand_idx    = j_q;
            end else if (entry_score < run_second_q) begin
                cand_second = entry_score;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        present_d    = present_q;
        score_buf_d  = score_buf_q;
        cnt_d        = cnt_q;
        j_d          = j_q;
        run_best_d   = run_best_q;
        run_second_d = run_second_q;
        run_idx_d    = run_idx_q;
        rank_idx_d   = rank_idx_q;
        best_d       = best_q;
        second_d     = second_q;
        conf_d       = conf_q;
        missing_d    = missing_q;
        valid_d      = valid_q;
        drop_d       = drop_q;
        any_strobe   = |score_valid;

        case (state_q)
            COLLECT: begin
                for (int i = 0; i < NUM_RANKS; i++) begin
                    if (score_valid[i]) begin
                        score_buf_d[i] = score_in[i*SCORE_W +: SCORE_W];
                        present_d[i]   = 1'b1;
                    end
                end
                // Counter only runs once at least one score has been latched.
                if (present_q != '0) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if ((&present_d) || (cnt_d == CNT_W'(TIMEOUT - 1))) begin
                    state_d      = COMPARE;
                    missing_d    = ~present_d;
                    j_d          = '0;
                    run_best_d   = SCORE_MAX;
                    run_second_d = SCORE_MAX;
                    run_idx_d    = '0;
                end
            end
            COMPARE: begin
                run_best_d   = cand_best;
                run_second_d = cand_second;
                run_idx_d    = cand_idx;
                j_d          = j_q + 1'b1;
                if (j_q == 4'(NUM_RANKS - 1)) begin
                    rank_idx_d = cand_idx;
                    best_d     = cand_best;
                    second_d   = cand_second;
                    // second >= best always, so the unsigned margin never wraps.
                    conf_d     = (cand_best < SCORE_W'(MATCH_THRESH)) &&
                                 ((cand_second - cand_best) >= SCORE_W'(MIN_MARGIN)) &&
                                 (missing_q == '0);
                    valid_d    = 1'b1;
                    state_d    = OUTPUT;
                end
                if (any_strobe && drop_q != 8'hFF) begin
                    drop_d = drop_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (rank_ready) begin
                    valid_d   = 1'b0;
                    present_d = '0;
                    cnt_d     = '0;
                    state_d   = COLLECT;
                end
                if (any_strobe && drop_q != 8'hFF) begin
                    drop_d = drop_q + 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            present_q    <= '0;
            cnt_q        <= '0;
            j_q          <= '0;
            run_best_q   <= SCORE_MAX;
            run_second_q <= SCORE_MAX;
            run_idx_q    <= '0;
            rank_idx_q   <= '0;
            best_q       <= '0;
            second_q     <= SCORE_MAX;
            conf_q       <= 1'b0;
            missing_q    <= '0;
            valid_q      <= 1'b0;
            drop_q       <= '0;
            for (int i = 0; i < NUM_RANKS; i++) begin
                score_buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            present_q    <= present_d;
            cnt_q        <= cnt_d;
            j_q          <= j_d;
            run_best_q   <= run_best_d;
            run_second_q <= run_second_d;
            run_idx_q    <= run_idx_d;
            rank_idx_q   <= rank_idx_d;
            best_q       <= best_d;
            second_q     <= second_d;
            conf_q       <= conf_d;
            missing_q    <= missing_d;
            valid_q      <= valid_d;
            drop_q       <= drop_d;
            score_buf_q  <= score_buf_d;
        end
    end

    assign rank_idx     = rank_idx_q;
    assign best_score   = best_q;
    assign second_score = second_q;
    assign confident    = conf_q;
    assign missing      = missing_q;
    assign rank_valid   = valid_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_rank_score_selector.sv
// Testbench for rank_score_selector: directed card scenarios followed by
// randomized cards, each checked against a behavioural model that derives
// the winner, runner-up, confidence, missing set and latency directly from
// the table of strobes applied.
module tb_rank_score_selector;

    localparam int NR   = 13;
    localparam int SW   = 11;
    localparam int TO   = 16;
    localparam int THR  = 300;
    localparam int MARG = 50;
    localparam int NCYC = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*SW-1:0] score_in;
    logic [NR-1:0]   score_valid;
    logic [3:0]      rank_idx;
    logic [SW-1:0]   best_score;
    logic [SW-1:0]   second_score;
    logic            confident;
    logic [NR-1:0]   missing;
    logic            rank_valid;
    logic            rank_ready;
    logic [7:0]      drop_count;

    rank_score_selector #(
        .NUM_RANKS(NR), .SCORE_W(SW), .TIMEOUT(TO),
        .MATCH_THRESH(THR), .MIN_MARGIN(MARG)
    ) dut (
        .clk(clk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
        .rank_idx(rank_idx), .best_score(best_score), .second_score(second_score),
        .confident(confident), .missing(missing), .rank_valid(rank_valid),
        .rank_ready(rank_ready), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Strobe table: cycle x rank.
    bit tab_v     [NCYC][NR];
    int tab_score [NCYC][NR];

    int         m_drop;
    int         e_idx, e_best, e_second, e_lat;
    bit         e_conf;
    logic [NR-1:0] e_missing;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tab();
        for (int c = 0; c < NCYC; c++)
            for (int r = 0; r < NR; r++) begin
                tab_v[c][r]     = 1'b0;
                tab_score[c][r] = 0;
            end
    endtask

    task automatic set_strobe(input int c, input int r, input int v);
        tab_v[c][r]     = 1'b1;
        tab_score[c][r] = v;
    endtask

    // Reference: last strobe per rank wins; best = smallest value at the
    // lowest index holding it; second = smallest among the other present ranks.
    task automatic compute_model();
        int  val [NR];
        bit  pres [NR];
        int  first_seen [NR];
        int  minv, first_any, complete;
        bit  all_present;
        for (int r = 0; r < NR; r++) begin
            pres[r] = 1'b0; val[r] = 0; first_seen[r] = -1;
        end
        for (int c = 0; c < NCYC; c++)
            for (int r = 0; r < NR; r++)
                if (tab_v[c][r]) begin
                    val[r] = tab_score[c][r];
                    pres[r] = 1'b1;
                    if (first_seen[r] < 0) first_seen[r] = c;
                end
        minv = 2047;
        for (int r = 0; r < NR; r++) if (pres[r] && val[r] < minv) minv = val[r];
        e_idx = 0;
        for (int r = NR - 1; r >= 0; r--) if (pres[r] && val[r] == minv) e_idx = r;
        e_best = minv;
        e_second = 2047;
        for (int r = 0; r < NR; r++)
            if (pres[r] && r != e_idx && val[r] < e_second) e_second = val[r];
        all_present = 1'b1;
        first_any = NCYC;
        complete = 0;
        for (int r = 0; r < NR; r++) begin
            e_missing[r] = !pres[r];
            if (!pres[r]) all_present = 1'b0;
            else begin
                if (first_seen[r] < first_any) first_any = first_seen[r];
                if (first_seen[r] > complete) complete = first_seen[r];
            end
        end
        e_conf = (e_best < THR) && ((e_second - e_best) >= MARG) && all_present;
        e_lat  = all_present ? complete + NR : first_any + (TO - 1) + NR;
    endtask

    task automatic drive_cycle(input int c);
        for (int r = 0; r < NR; r++) begin
            score_valid[r] = tab_v[c][r];
            score_in[r*SW +: SW] = tab_v[c][r] ? SW'(tab_score[c][r]) : SW'($urandom_range(0, 2047));
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},   64'(rank_valid),   64'(1'b1));
        check({tag, ".idx"},     64'(rank_idx),     64'(e_idx));
        check({tag, ".best"},    64'(best_score),   64'(e_best));
        check({tag, ".second"},  64'(second_score), 64'(e_second));
        check({tag, ".conf"},    64'(confident),    64'(e_conf));
        check({tag, ".missing"}, 64'(missing),      64'(e_missing));
    endtask

    // Caller is at a negedge; table cycle c is sampled by the c-th posedge.
    task automatic run_card(input string tag);
        int t;
        compute_model();
        for (int c = 0; c < NCYC; c++) begin
            drive_cycle(c);
            @(negedge clk);
        end
        score_valid = '0;
        t = NCYC - 1;
        while (rank_valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, ".latency"}, 64'(t), 64'(e_lat));
        check_outputs(tag);
    endtask

    task automatic accept(input int hold, input int pct);
        for (int h = 0; h < hold; h++) begin
            check("hold.stable",
                  64'({rank_valid, rank_idx, best_score, second_score, confident, missing}),
                  64'({1'b1, 4'(e_idx), SW'(e_best), SW'(e_second), e_conf, e_missing}));
            if ($urandom_range(0, 99) < pct) begin
                score_valid = NR'($urandom_range(1, 8191));
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end else begin
                score_valid = '0;
            end
            @(negedge clk);
        end
        rank_ready = 1'b1;
        if ($urandom_range(0, 99) < pct) begin
            score_valid = NR'($urandom_range(1, 8191));
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else begin
            score_valid = '0;
        end
        @(negedge clk);
        rank_ready  = 1'b0;
        score_valid = '0;
        check("accept.valid_low", 64'(rank_valid), 64'(1'b0));
        check("drop_count",       64'(drop_count), 64'(m_drop));
    endtask

    task automatic gen_random(input bit full);
        int off [NR];
        bit inc [NR];
        int base, a, b, d, o2, limit, complete;
        clear_tab();
        base = $urandom_range(0, 400);
        for (int r = 0; r < NR; r++) begin
            off[r] = $urandom_range(0, NCYC - 1);
            inc[r] = full ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
        if (!full) begin
            a = $urandom_range(0, NR - 1);
            b = (a + 1 + $urandom_range(0, NR - 2)) % NR;
            inc[a] = 1'b1;
            inc[b] = 1'b0;
        end
        complete = 0;
        for (int r = 0; r < NR; r++)
            if (inc[r]) begin
                set_strobe(off[r], r, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2000)
                                                                   : base + $urandom_range(0, 200));
                if (off[r] > complete) complete = off[r];
            end
        // Re-strobe one rank before collection closes so it is overwritten.
        limit = full ? complete : NCYC - 1;
        d = $urandom_range(0, NR - 1);
        if (inc[d] && off[d] < limit) begin
            o2 = $urandom_range(off[d] + 1, limit);
            set_strobe(o2, d, $urandom_range(0, 2000));
        end
    endtask

    initial begin
        bit rose;
        rst = 1'b1;
        rank_ready = 1'b0;
        score_valid = '0;
        score_in = '0;
        m_drop = 0;
        repeat (2) @(negedge clk);
        check("reset.valid",   64'(rank_valid),   64'(1'b0));
        check("reset.idx",     64'(rank_idx),     64'(0));
        check("reset.best",    64'(best_score),   64'(0));
        check("reset.second",  64'(second_score), 64'(2047));
        check("reset.conf",    64'(confident),    64'(1'b0));
        check("reset.missing", 64'(missing),      64'(0));
        check("reset.drop",    64'(drop_count),   64'(0));
        rst = 1'b0;
        @(negedge clk);

        // All ranks in one cycle: clear winner.
        clear_tab();
        for (int r = 0; r < NR; r++) set_strobe(0, r, 900);
        set_strobe(0, 6, 40);
        set_strobe(0, 2, 400);
        run_card("same_cycle");
        accept(0, 0);

        // Ready while idle must not disturb anything.
        rank_ready = 1'b1;
        repeat (3) @(negedge clk);
        rank_ready = 1'b0;

        // Staggered, tie between ranks 3 and 9.
        clear_tab();
        for (int r = 0; r < NR; r++) set_strobe(r, r, 1000);
        tab_score[3][3] = 120;
        tab_score[9][9] = 120;
        run_card("stagger_tie");
        accept(1, 0);

        // Rank 12 never strobes: timeout path.
        clear_tab();
        for (int r = 0; r < NR - 1; r++) set_strobe(0, r, 900);
        set_strobe(0, 5, 10);
        run_card("timeout");
        accept(2, 0);

        // Reset mid-COMPARE aborts the card.
        clear_tab();
        for (int r = 0; r < NR; r++) set_strobe(0, r, 500);
        drive_cycle(0);
        @(negedge clk);
        score_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_drop = 0;
        check("rst_mid.valid",  64'(rank_valid),   64'(1'b0));
        check("rst_mid.second", 64'(second_score), 64'(2047));
        check("rst_mid.drop",   64'(drop_count),   64'(0));
        rose = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rank_valid === 1'b1) rose = 1'b1;
        end
        check("rst_mid.no_result", 64'(rose), 64'(1'b0));

        clear_tab();
        for (int r = 0; r < NR; r++) set_strobe(0, r, 700 + r);
        set_strobe(0, 11, 200);
        run_card("after_reset");
        // Long hold with strobes injected: drop_count counts strobe cycles.
        accept(20, 50);

        // Single rank present at timeout.
        clear_tab();
        set_strobe(0, 4, 100);
        run_card("single");
        accept(0, 0);

        // Randomized cards.
        for (int n = 0; n < 40; n++) begin
            gen_random($urandom_range(0, 3) != 0);
            run_card("random");
            accept($urandom_range(0, 3), 30);
        end

        // drop_count saturation.
        clear_tab();
        for (int r = 0; r < NR; r++) set_strobe($urandom_range(0, 12), r, $urandom_range(0, 2000));
        run_card("saturate");
        accept(270, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
